// File: rtl/core_debug_pkg.sv
// Shared types for the z8 core debug controller: FSM states, dump beat tags
// and the bit positions of the core flags.
package core_debug_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DUMP_REG,
    DUMP_MEM,
    DUMP_FLAGS,
    DONE
  } dbg_state_t;

  typedef enum logic [1:0] {
    TAG_REG   = 2'd0,
    TAG_MEM   = 2'd1,
    TAG_FLAGS = 2'd2
  } dbg_tag_t;

  localparam int FLAG_ZERO     = 0;
  localparam int FLAG_NEGATIVE = 1;
  localparam int FLAG_CARRY    = 2;
  localparam int FLAG_OVERFLOW = 3;

  // A sequence is in progress everywhere except the two resting states.
  function automatic logic is_busy(dbg_state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/core_debug_controller_skid.sv
// dbg_out_skid: single-entry output register for the dump stream. Fields are
// only loaded when the slot is free, so they cannot change while a beat is
// stalled by out_ready.
module dbg_out_skid
  import core_debug_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  dbg_tag_t          push_tag,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  output logic              free,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_tag,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  assign free = !out_valid || out_ready;

  // Load a new beat into an empty or just-accepted slot; otherwise hold it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_tag   <= TAG_REG;
      out_addr  <= '0;
      out_data  <= '0;
    end else if (push && free) begin
      out_valid <= 1'b1;
      out_tag   <= push_tag;
      out_addr  <= push_addr;
      out_data  <= push_data;
      out_last  <= push_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/core_debug_controller.sv
// core_debug_controller: loads a program into the z8 core, runs it until halt
// and streams back registers, a data-memory window and the flags.
// Optional run-phase watchdog: define CORE_DBG_WATCHDOG_EN.
//
// state      | meaning
// IDLE       | core held in reset, waiting for start
// LOAD       | accepting instruction words into program memory
// RUN        | core released, waiting for core_halted (or watchdog)
// DUMP_REG   | one beat per register 0..NUM_REGS-1
// DUMP_MEM   | read dump_base.. for dump_len words, one beat each
// DUMP_FLAGS | single flags beat carrying out_last
// DONE       | sequence complete, core left halted
module core_debug_controller
  import core_debug_pkg::*;
#(
  parameter int OPCODE_W    = 8,
  parameter int DATA_W      = 16,
  parameter int PROG_DEPTH  = 256,
  parameter int DATA_DEPTH  = 256,
  parameter int NUM_REGS    = 4,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [$clog2(DATA_DEPTH)-1:0]   dump_base,
  input  logic [$clog2(DATA_DEPTH):0]     dump_len,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [OPCODE_W+2*DATA_W-1:0]    in_data,
  input  logic                            in_last,
  output logic                            core_reset,
  input  logic                            core_halted,
  output logic                            pm_we,
  output logic [$clog2(PROG_DEPTH)-1:0]   pm_addr,
  output logic [OPCODE_W+2*DATA_W-1:0]    pm_wdata,
  output logic [$clog2(NUM_REGS)-1:0]     rf_raddr,
  input  logic [DATA_W-1:0]               rf_rdata,
  output logic [$clog2(DATA_DEPTH)-1:0]   dm_raddr,
  input  logic [DATA_W-1:0]               dm_rdata,
  input  logic [3:0]                      core_flags,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [1:0]                      out_tag,
  output logic [$clog2(DATA_DEPTH)-1:0]   out_addr,
  output logic [DATA_W-1:0]               out_data,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done,
  output logic                            timeout
);

  localparam int DA_W = $clog2(DATA_DEPTH);
  localparam int RA_W = $clog2(NUM_REGS);

  dbg_state_t        state, next_state;
  logic [DA_W-1:0]   base_q;
  logic [DA_W:0]     len_q;
  logic [RA_W-1:0]   reg_idx;
  logic [DA_W-1:0]   mem_addr;
  logic [DA_W:0]     mem_left;
  logic              rd_ok;
  logic              start_acc;
  logic              wdog_fire;
  logic              push, push_last, free;
  dbg_tag_t          push_tag;
  logic [DA_W-1:0]   push_addr;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] flags_word;

  assign start_acc = start && ((state == IDLE) || (state == DONE));
  assign in_ready  = (state == LOAD);
  assign pm_we     = in_ready && in_valid;
  assign pm_wdata  = in_data;
  assign rf_raddr  = reg_idx;
  assign dm_raddr  = mem_addr;
  assign busy      = is_busy(state);
  assign done      = (state == DONE);

`ifdef CORE_DBG_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt;

  // Down-counter over RUN cycles; terminal count on the last allowed cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (state == LOAD && next_state == RUN)
        wdog_cnt <= WDOG_W'(WDOG_CYCLES - 1);
      else if (state == RUN && wdog_cnt != '0)
        wdog_cnt <= wdog_cnt - 1'b1;
      if (start_acc)
        timeout <= 1'b0;
      else if (wdog_fire)
        timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode and dump beat generation.
  always_comb begin
    next_state = state;
    push       = 1'b0;
    push_tag   = TAG_REG;
    push_addr  = '0;
    push_data  = '0;
    push_last  = 1'b0;
    wdog_fire  = 1'b0;
    flags_word = '0;
    flags_word[FLAG_ZERO]     = core_flags[FLAG_ZERO];
    flags_word[FLAG_NEGATIVE] = core_flags[FLAG_NEGATIVE];
    flags_word[FLAG_CARRY]    = core_flags[FLAG_CARRY];
    flags_word[FLAG_OVERFLOW] = core_flags[FLAG_OVERFLOW];
    case (state)
      IDLE, DONE: if (start) next_state = LOAD;
      LOAD:       if (in_valid && in_last) next_state = RUN;
      RUN: begin
        if (core_halted) next_state = DUMP_REG;
`ifdef CORE_DBG_WATCHDOG_EN
        else if (wdog_cnt == '0) begin
          wdog_fire  = 1'b1;
          next_state = DUMP_REG;
        end
`endif
      end
      DUMP_REG: if (free) begin
        push      = 1'b1;
        push_tag  = TAG_REG;
        push_addr = DA_W'(reg_idx);
        push_data = rf_rdata;
        if (reg_idx == RA_W'(NUM_REGS - 1))
          next_state = (len_q == '0) ? DUMP_FLAGS : DUMP_MEM;
      end
      DUMP_MEM: if (rd_ok && free) begin
        push      = 1'b1;
        push_tag  = TAG_MEM;
        push_addr = mem_addr;
        push_data = dm_rdata;
        if (mem_left == (DA_W+1)'(1)) next_state = DUMP_FLAGS;
      end
      DUMP_FLAGS: if (free) begin
        push       = 1'b1;
        push_tag   = TAG_FLAGS;
        push_data  = flags_word;
        push_last  = 1'b1;
        next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Load/dump counters and the registered core reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pm_addr    <= '0;
      base_q     <= '0;
      len_q      <= '0;
      reg_idx    <= '0;
      mem_addr   <= '0;
      mem_left   <= '0;
      rd_ok      <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      if (start_acc) begin
        pm_addr  <= '0;
        base_q   <= dump_base;
        len_q    <= dump_len;
        reg_idx  <= '0;
        mem_addr <= dump_base;
        mem_left <= dump_len;
      end else if (pm_we) begin
        pm_addr <= pm_addr + 1'b1;
      end
      if (state == DUMP_REG && push) reg_idx <= reg_idx + 1'b1;
      if (state == DUMP_MEM) begin
        if (push) begin
          rd_ok    <= 1'b0;
          mem_addr <= mem_addr + 1'b1;
          mem_left <= mem_left - 1'b1;
        end else begin
          rd_ok <= 1'b1;
        end
      end else begin
        rd_ok <= 1'b0;
      end
      core_reset <= (next_state == IDLE) || (next_state == LOAD) || wdog_fire || timeout;
    end
  end

  dbg_out_skid #(.ADDR_W(DA_W), .DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_tag  (push_tag),
    .push_addr (push_addr),
    .push_data (push_data),
    .push_last (push_last),
    .free      (free),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  // base_q is kept for visibility of the captured window start.
  logic unused_base;
  assign unused_base = ^base_q;

endmodule

// File: tb/tb_core_debug_controller.sv
// Scoreboard bench for core_debug_controller: stimulus tasks push expected
// program writes and dump beats; negedge monitors pop and compare.
module tb_core_debug_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  dump_base = '0;
  logic [8:0]  dump_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [39:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        core_reset;
  logic        core_halted;
  logic        pm_we;
  logic [7:0]  pm_addr;
  logic [39:0] pm_wdata;
  logic [1:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic [7:0]  dm_raddr;
  logic [15:0] dm_rdata;
  logic [3:0]  core_flags = 4'b1010;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_tag;
  logic [7:0]  out_addr;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy, done, timeout;

  always #5 clk = ~clk;

  core_debug_controller #(.WDOG_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .start(start), .dump_base(dump_base), .dump_len(dump_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .core_reset(core_reset), .core_halted(core_halted),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
    .core_flags(core_flags), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .timeout(timeout)
  );

  // Hand-chosen register contents (R1 = 8000h from LDD R1,8000h); flags 1010b -> 000Ah.
  logic [15:0] exp_reg [4] = '{16'h0000, 16'h8000, 16'h1234, 16'hBEEF};
  logic [39:0] prog_a  [4] = '{40'h01_0000_0000, 40'h01_0001_8000, 40'h05_0000_0001, 40'hFF_0000_0000};
  logic [39:0] prog_b  [2] = '{40'h01_0000_0000, 40'h0A_0000_0001};

  // Core-side models: combinational register file, 1-cycle data memory, halt after a few run cycles.
  logic [15:0] dm [256];
  int          run_cnt;
  logic        halt_en = 1'b0;
  logic        ready_mode = 1'b0;
  assign rf_rdata = exp_reg[rf_raddr];
  always @(posedge clk) dm_rdata <= dm[dm_raddr];
  always @(posedge clk) begin
    if (core_reset) begin
      run_cnt     <= 0;
      core_halted <= 1'b0;
    end else begin
      run_cnt <= run_cnt + 1;
      if (halt_en && run_cnt >= 4) core_halted <= 1'b1;
    end
  end
  always @(posedge clk) begin
    #1;
    out_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int tests = 0;
  int fails = 0;
  int beat_cnt = 0;
  int last_cnt = 0;
  logic [26:0] exp_q [$];
  logic [47:0] pm_q  [$];
  logic        stall_prev = 1'b0;
  logic [26:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Program-write monitor.
  always @(negedge clk) begin
    if (!reset && pm_we) begin
      if (pm_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL pm_unexpected: got addr %0h data %0h, none expected", pm_addr, pm_wdata);
      end else begin
        check("pm_write", {pm_addr, pm_wdata}, pm_q.pop_front());
      end
    end
  end

  // Dump-stream monitor: hold stability while stalled, then in-order compare on acceptance.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else if (out_valid) begin
      if (stall_prev) check("hold_stable", {out_tag, out_addr, out_data, out_last}, held);
      if (out_ready) begin
        beat_cnt++;
        if (out_last) last_cnt++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL beat_unexpected: got %0h, none expected", {out_tag, out_addr, out_data, out_last});
        end else begin
          check("beat", {out_tag, out_addr, out_data, out_last}, exp_q.pop_front());
        end
        stall_prev = 1'b0;
      end else begin
        stall_prev = 1'b1;
        held = {out_tag, out_addr, out_data, out_last};
      end
    end else begin
      if (stall_prev) check("valid_held", out_valid, 1);
      stall_prev = 1'b0;
    end
  end

  task automatic fill_exp(input logic [7:0] base, input logic [8:0] len);
    logic [7:0] a;
    for (int r = 0; r < 4; r++) exp_q.push_back({2'd0, 8'(r), exp_reg[r], 1'b0});
    for (int k = 0; k < int'(len); k++) begin
      a = base + 8'(k);
      exp_q.push_back({2'd1, a, 16'hD000 + {8'h00, a}, 1'b0});
    end
    exp_q.push_back({2'd2, 8'h00, 16'h000A, 1'b1});
  endtask

  task automatic start_load(input logic [7:0] base, input logic [8:0] len, input bit loop_prog);
    int nb;
    nb = loop_prog ? 2 : 4;
    beat_cnt = 0;
    last_cnt = 0;
    dump_base = base;
    dump_len  = len;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("core_reset_load", core_reset, 1);
    check("timeout_clear", timeout, 0);
    for (int i = 0; i < nb; i++) begin
      in_valid = 1'b1;
      in_data  = loop_prog ? prog_b[i] : prog_a[i];
      in_last  = (i == nb - 1);
      pm_q.push_back({8'(i), in_data});
      check("in_ready_load", in_ready, 1);
      if (i == nb - 1) check("core_reset_last_beat", core_reset, 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("core_reset_run", core_reset, 0);
  endtask

  task automatic finish_seq(input int nbeats);
    int n;
    n = 0;
    while (!done && n < 3000) begin tick(); n++; end
    check("done_reached", done, 1);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    check("queue_drained", exp_q.size(), 0);
    check("beat_count", beat_cnt, nbeats);
    check("last_count", last_cnt, 1);
    check("busy_done", busy, 0);
  endtask

  task automatic run_seq(input logic [7:0] base, input logic [8:0] len, input bit rnd);
    ready_mode = rnd;
    halt_en = 1'b1;
    fill_exp(base, len);
    start_load(base, len, 1'b0);
    finish_seq(5 + int'(len));
    check("core_reset_in_done", core_reset, 0);
    check("timeout_normal", timeout, 0);
    ready_mode = 1'b0;
  endtask

  task automatic reset_and_check(input string tag);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check({tag, "_core_reset"}, core_reset, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    exp_q.delete();
    pm_q.delete();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) dm[i] = 16'hD000 + 16'(i);
    repeat (3) tick();
    check("rst_core_reset", core_reset, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_pm_we", pm_we, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_pm_addr", pm_addr, 0);
    reset = 1'b0;
    tick();

    run_seq(8'h00, 9'd4, 1'b0);
    run_seq(8'h00, 9'd4, 1'b1);
    run_seq(8'hFE, 9'd4, 1'b0);
    run_seq(8'h10, 9'd0, 1'b0);
    run_seq(8'hFE, 9'd4, 1'b1);

    // Reset while the core is running.
    halt_en = 1'b0;
    start_load(8'h00, 9'd4, 1'b0);
    repeat (3) tick();
    check("run_busy", busy, 1);
    reset_and_check("rst_in_run");

    // Reset part-way through the memory window.
    halt_en = 1'b1;
    fill_exp(8'h00, 9'd8);
    start_load(8'h00, 9'd8, 1'b0);
    n = 0;
    while (beat_cnt < 5 && n < 500) begin tick(); n++; end
    check("reached_dump_mem", beat_cnt >= 5, 1);
    check("dump_mem_busy", busy, 1);
    reset_and_check("rst_in_dump_mem");
    tick();

`ifdef CORE_DBG_WATCHDOG_EN
    halt_en = 1'b0;
    fill_exp(8'h20, 9'd2);
    start_load(8'h20, 9'd2, 1'b1);
    n = 0;
    while (!timeout && n < 300) begin tick(); n++; end
    check("wdog_run_cycles", n, 100);
    check("wdog_core_reset", core_reset, 1);
    finish_seq(7);
    check("wdog_timeout_sticky", timeout, 1);
    run_seq(8'h00, 9'd4, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule

// File: doc/core_debug_controller.md
Name: core_debug_controller

Overview:
Synthesisable load/run/dump controller for z8ProcessorCore, replacing hierarchical pokes and peeks into program memory, register file and flags with a hardware sequence. Streams a program into program memory, holds the core in reset until loading is complete, then releases it and waits for halt. After halt it streams out the register file, a data-memory window and the flags. It sits between a host stream interface and the core's debug-side memory and register ports.

Parameters:
OPCODE_W, 8, opcode field width; instruction word is OPCODE_W+2*DATA_W bits
DATA_W, 16, register, data-memory and operand width
PROG_DEPTH, 256, program memory words (power of 2)
DATA_DEPTH, 256, data memory words (power of 2)
NUM_REGS, 4, registers dumped
WDOG_CYCLES, 65535, run-phase cycle limit (used only when the watchdog feature is compiled in)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a load/run/dump sequence when in IDLE
dump_base  in  $clog2(DATA_DEPTH)  first data-memory address dumped; sampled on start
dump_len  in  $clog2(DATA_DEPTH)+1  words dumped; sampled on start; 0 = none
in_valid / in_ready  in / out  1  program load handshake
in_data  in  OPCODE_W+2*DATA_W  instruction word
in_last  in  1  marks final instruction
core_reset  out  1  reset to the core
core_halted  in  1  core halt status
pm_we  out  1  program memory write strobe
pm_addr  out  $clog2(PROG_DEPTH)  program memory write address
pm_wdata  out  OPCODE_W+2*DATA_W  program memory write data
rf_raddr  out  $clog2(NUM_REGS)  register read address; rf_rdata combinational
rf_rdata  in  DATA_W  register read data
dm_raddr  out  $clog2(DATA_DEPTH)  data-memory read address; dm_rdata 1-cycle latency
dm_rdata  in  DATA_W  data-memory read data
core_flags  in  4  {overflow, carry, negative, zero}
out_valid / out_ready  out / in  1  dump handshake
out_tag  out  2  0=REG, 1=MEM, 2=FLAGS
out_addr  out  $clog2(DATA_DEPTH)  register index or memory address
out_data  out  DATA_W  value; FLAGS uses bits [3:0], upper bits zero
out_last  out  1  final dump beat
busy  out  1  high outside IDLE and DONE
done  out  1  high in DONE
timeout  out  1  sticky; watchdog fired

Behaviour:
- Reset values: core_reset=1, in_ready=0, pm_we=0, out_valid=0, out_last=0, busy=0, done=0, timeout=0, pm_addr=0; state=IDLE. Reset mid-sequence aborts to IDLE, with core_reset=1 from the next cycle.
- IDLE: core_reset=1. start -> LOAD, pm_addr cleared, dump_base and dump_len captured. start outside IDLE/DONE is ignored.
- LOAD: in_ready=1. Each in_valid&&in_ready beat gives pm_we=1 the same cycle, with pm_addr/pm_wdata from the counter and in_data. The counter then increments and wraps at PROG_DEPTH. A beat with in_last -> RUN.
- RUN: core_reset=0 starting on the first RUN cycle. core_halted=1 sampled -> DUMP_REG.
- DUMP_REG: beats for indices 0..NUM_REGS-1 with tag REG.
- DUMP_MEM: for each address, issue dm_raddr, wait one cycle, present the beat. Addresses run dump_base..dump_base+dump_len-1, wrapping modulo DATA_DEPTH. dump_len=0 skips this state.
- DUMP_FLAGS: one beat with tag FLAGS and out_last=1 -> DONE.
- Output rule: while out_valid&&!out_ready, all out_* fields are held stable. The next beat is presented no earlier than the cycle after acceptance. out_valid never drops without acceptance.
- DONE: core_reset stays 0 and the core stays halted. start -> LOAD for a new sequence; core_reset=1 asserts on that transition.
- Arithmetic: all counters unsigned and wrap by width, with no saturation.

Optional Feature:
CORE_DBG_WATCHDOG_EN.
- Defined: a RUN cycle counter. Reaching WDOG_CYCLES without core_halted sets timeout=1, forces core_reset=1, and goes to DUMP_REG. The dump proceeds normally. timeout clears only on reset or on the next start.
- Undefined: no counter exists, RUN waits indefinitely, and timeout is tied to 0.

Decomposition:
- Package core_debug_pkg holds the state enum {IDLE, LOAD, RUN, DUMP_REG, DUMP_MEM, DUMP_FLAGS, DONE}, the tag enum and the flags bit positions.
- Opcode constants stay in instruction_set.
- One sub-module, dbg_out_skid, is natural: it is the output register/hold stage implementing the stable-under-backpressure rule.

Test Plan:
- Load {LDD R0,0},{LDD R1,8000h},{SBR R0,R1},{HALT} with in_last on beat 3 -> pm writes at addresses 0..3; core_reset drops the cycle after beat 3; the halt is detected.
- Same run with dump_base=0, dump_len=4, out_ready=1 -> 4 REG beats, then 4 MEM beats, then one FLAGS beat. R1 reads 8000h. Exactly one out_last, on the FLAGS beat.
- Random out_ready (50% duty) -> no beat lost or duplicated; fields stable while stalled; same sequence as with out_ready tied 1.
- dump_base=FEh, dump_len=4 -> MEM addresses FE, FF, 00, 01. dump_len=0 -> REG beats go straight to the FLAGS beat.
- Reset asserted in RUN and in DUMP_MEM -> next cycle core_reset=1, out_valid=0, busy=0, state IDLE.
- With CORE_DBG_WATCHDOG_EN and WDOG_CYCLES=100, load a loop with no HALT -> timeout=1 at cycle 100 of RUN; the dump completes with out_last on FLAGS.
